// File: rtl/ppm_pkg.sv
// Shared types, defaults and helpers for the PPM receive controller.
package ppm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } ppm_state_e;

  localparam int unsigned PPM_SLOT_LEN   = 16;
  localparam int unsigned PPM_SAMPLE_POS = 4;
  localparam int unsigned PPM_MAX_BYTES  = 32;
  localparam int unsigned PPM_SYM_W      = 2;

  // Number of hit slots in a symbol.
  function automatic logic [2:0] hit_count(input logic [3:0] hits);
    logic [2:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt = cnt + 3'(hits[i]);
    end
    return cnt;
  endfunction

  // Slot index of the highest hit; meaningful only for a single hit.
  function automatic logic [PPM_SYM_W-1:0] hit_index(input logic [3:0] hits);
    logic [PPM_SYM_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (hits[i]) idx = PPM_SYM_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ppm_slot_timer.sv
// Slot/symbol timing for 1-of-4 PPM: cycle-in-slot, slot index and symbol
// index, plus sample and end-of-symbol strobes.
module ppm_slot_timer
  import ppm_pkg::*;
#(
  parameter int unsigned SLOT_LEN   = PPM_SLOT_LEN,
  parameter int unsigned SAMPLE_POS = PPM_SAMPLE_POS
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_restart,
  output logic [1:0] o_slot,
  output logic [1:0] o_sym,
  output logic       o_sample_stb,
  output logic       o_eos_stb
);

  localparam int unsigned CW = $clog2(SLOT_LEN);

  logic [CW-1:0] r_cyc;
  logic [1:0]    r_slot;
  logic [1:0]    r_sym;
  logic          w_slot_end;

  assign w_slot_end = (r_cyc == CW'(SLOT_LEN - 1));

  // Free-running counters; restart holds them at slot 0, cycle 0.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_restart) begin
      r_cyc  <= '0;
      r_slot <= '0;
      r_sym  <= '0;
    end else begin
      r_cyc <= r_cyc + CW'(1);
      if (w_slot_end) begin
        r_slot <= r_slot + 2'd1;
        if (r_slot == 2'd3) r_sym <= r_sym + 2'd1;
      end
    end
  end

  assign o_slot       = r_slot;
  assign o_sym        = r_sym;
  assign o_sample_stb = !i_restart && (r_cyc == CW'(SAMPLE_POS));
  assign o_eos_stb    = !i_restart && w_slot_end && (r_slot == 2'd3);

endmodule

// File: rtl/ppm_rx_ctrl.sv
// PPM receive controller: collects slot hits, decodes 1-of-4 symbols,
// assembles bytes LSB-first and sequences frame completion or abort.
module ppm_rx_ctrl
  import ppm_pkg::*;
#(
  parameter int unsigned SLOT_LEN   = PPM_SLOT_LEN,
  parameter int unsigned SAMPLE_POS = PPM_SAMPLE_POS,
  parameter int unsigned MAX_BYTES  = PPM_MAX_BYTES
) (
  input  logic       clk16,
  input  logic       rst,
  input  logic       din,
  input  logic       sof_rcv,
  input  logic       en,
  output logic       det_clr,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic [5:0] byte_cnt,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err
);

  ppm_state_e r_state;
  ppm_state_e w_state_nxt;

  logic [3:0]             r_hits;
  logic [3*PPM_SYM_W-1:0] r_asm;
  logic [7:0]             r_data;
  logic [5:0]             r_byte_cnt;
  logic                   r_valid;

  logic                 w_restart;
  logic [1:0]           w_slot;
  logic [1:0]           w_sym;
  logic                 w_sample;
  logic                 w_eos;
  logic [3:0]           w_hits_now;
  logic [2:0]           w_nhits;
  logic [PPM_SYM_W-1:0] w_val;
  logic                 w_start;
  logic                 w_deliver;

  assign w_restart = (r_state != ST_DATA);

  ppm_slot_timer #(
    .SLOT_LEN  (SLOT_LEN),
    .SAMPLE_POS(SAMPLE_POS)
  ) u_timer (
    .i_clk       (clk16),
    .i_rst       (rst),
    .i_restart   (w_restart),
    .o_slot      (w_slot),
    .o_sym       (w_sym),
    .o_sample_stb(w_sample),
    .o_eos_stb   (w_eos)
  );

  // Include the current cycle's sample so the decision never misses a hit
  // that lands on the end-of-symbol cycle.
  assign w_hits_now = r_hits | ((w_sample && !din) ? (4'b0001 << w_slot) : 4'b0000);
  assign w_nhits    = hit_count(w_hits_now);
  assign w_val      = hit_index(w_hits_now);
  assign w_start    = (r_state == ST_IDLE) && sof_rcv && en;

  // State register.
  always_ff @(posedge clk16) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state, byte-delivery decision and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_deliver   = 1'b0;
    busy        = (r_state != ST_IDLE);
    frame_done  = (r_state == ST_DONE);
    frame_err   = (r_state == ST_ERR);
    det_clr     = (r_state == ST_DONE) || (r_state == ST_ERR);
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (!en) begin
          w_state_nxt = ST_ERR;
        end else if (w_eos) begin
          if (w_nhits == 3'd0) begin
            w_state_nxt = (w_sym == 2'd0) ? ST_DONE : ST_ERR;
          end else if (w_nhits != 3'd1) begin
            w_state_nxt = ST_ERR;
          end else if (w_sym == 2'd3) begin
            if (r_byte_cnt == 6'(MAX_BYTES)) w_state_nxt = ST_ERR;
            else                             w_deliver   = 1'b1;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      ST_ERR:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Hit accumulation, symbol packing, byte output and byte counter.
  always_ff @(posedge clk16) begin
    if (rst) begin
      r_hits     <= '0;
      r_asm      <= '0;
      r_data     <= '0;
      r_byte_cnt <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= w_deliver;
      if (w_start) r_byte_cnt <= '0;
      if (r_state != ST_DATA || w_eos) r_hits <= '0;
      else                             r_hits <= w_hits_now;
      if (r_state == ST_DATA && en && w_eos && w_nhits == 3'd1) begin
        case (w_sym)
          2'd0:    r_asm[1:0] <= w_val;
          2'd1:    r_asm[3:2] <= w_val;
          2'd2:    r_asm[5:4] <= w_val;
          default: ;
        endcase
      end
      if (w_deliver) begin
        r_data     <= {w_val, r_asm};
        r_byte_cnt <= r_byte_cnt + 6'd1;
      end
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign byte_cnt   = r_byte_cnt;

endmodule

// File: doc/ppm_rx_ctrl.md
PPM_RX_CTRL -- requirements
Module: ppm_rx_ctrl

Interface
REQ-001 Parameter SLOT_LEN, default 16; clk16 cycles per PPM slot; power of two, at least 8.
REQ-002 Parameter SAMPLE_POS, default 4; cycle offset inside a slot at which din is sampled.
REQ-003 Parameter MAX_BYTES, default 32; maximum data bytes per frame.
REQ-004 Port clk16, input, 1 bit; single clock, 16x oversampling rate.
REQ-005 Port rst, input, 1 bit; reset, synchronous and active-high.
REQ-006 Port din, input, 1 bit; PPM line, already synchronised; low means pulse.
REQ-007 Port sof_rcv, input, 1 bit; one-cycle pulse from the SOF detector.
REQ-008 Port en, input, 1 bit; receiver enable.
REQ-009 Port det_clr, output, 1 bit; one-cycle pulse that re-arms the SOF detector.
REQ-010 Port data_out, output, 8 bits; assembled byte.
REQ-011 Port data_valid, output, 1 bit; one-cycle strobe qualifying data_out.
REQ-012 Port byte_cnt, output, 6 bits; bytes delivered in the current frame.
REQ-013 Port busy, output, 1 bit; high in every state except IDLE.
REQ-014 Port frame_done, output, 1 bit; one-cycle pulse on a valid EOF.
REQ-015 Port frame_err, output, 1 bit; one-cycle pulse on frame abort.

Function
REQ-016 State machine shall have the states IDLE, DATA, DONE and ERR.
REQ-017 IDLE shall transition to DATA when sof_rcv and en are both high on the same cycle; sof_rcv shall be ignored while en is low.
REQ-018 On entry to DATA, the slot timer shall restart at slot 0, cycle 0 on the cycle after sof_rcv.
REQ-019 Symbol format: 1-of-4 PPM, with each symbol lasting 4*SLOT_LEN cycles.
REQ-020 din shall be sampled once per slot, at slot cycle SAMPLE_POS.
REQ-021 A slot shall be marked "hit" when its sample is din = 0.
REQ-022 Symbol with exactly one hit: the hit slot index (0..3) is the 2-bit symbol value.
REQ-023 Symbols shall be packed LSB-first: symbol k goes to bits [2k+1:2k], for k = 0..3.
REQ-024 After the 4th symbol of a byte, data_out shall update and data_valid shall pulse exactly 1 cycle after the last slot's final cycle; byte_cnt shall increment on that same cycle.
REQ-025 Symbol with zero hits and a symbol counter of 0 (byte boundary) is EOF; the FSM shall go to DONE, and DONE shall go to IDLE after 1 cycle.
REQ-026 Symbol with zero hits at a non-zero symbol counter is an error; the FSM shall go to ERR.
REQ-027 Symbol with 2 or more hits is an error; the FSM shall go to ERR.
REQ-028 A 4th symbol that would deliver byte MAX_BYTES+1 is overflow; the FSM shall go to ERR, and the byte shall not be delivered.
REQ-029 en falling while in DATA shall cause a transition to ERR on the next cycle.
REQ-030 EOF with byte_cnt = 0 shall be legal: frame_done pulses and byte_cnt stays 0.
REQ-031 frame_done shall pulse during the DONE cycle.
REQ-032 frame_err shall pulse during the ERR cycle, and ERR shall go to IDLE after 1 cycle.
REQ-033 det_clr shall pulse during the DONE cycle and during the ERR cycle.
REQ-034 byte_cnt shall hold its final value in IDLE and shall clear on the next DATA entry.
REQ-035 data_out shall hold its last byte until overwritten.
REQ-036 sof_rcv arriving during DATA, DONE or ERR shall be ignored.
REQ-037 Slot and symbol counters shall wrap modulo SLOT_LEN and modulo 4 respectively, with no gap between symbols.

Reset
REQ-038 While rst is high at a clk16 edge, the FSM shall be in IDLE and the counters shall be 0.
REQ-039 Reset values: data_out = 0, byte_cnt = 0; data_valid, frame_done, frame_err, det_clr and busy all 0.
REQ-040 rst asserted mid-frame shall abort the frame with no frame_err and no det_clr pulse.

Structure
REQ-041 Package ppm_pkg shall hold the state encoding, the default SLOT_LEN, SAMPLE_POS and MAX_BYTES values, and the symbol-width constant 2.
REQ-042 Sub-module ppm_slot_timer shall provide the slot cycle counter, the 2-bit slot index, the 2-bit symbol index, the sample strobe and the end-of-symbol strobe, with a synchronous restart input.
REQ-043 Hit accumulation, byte assembly and the FSM shall live in ppm_rx_ctrl.

Verification
REQ-044 en = 1, sof_rcv, symbols 1,0,3,2, then EOF -> data_out = 8'hB1 with one data_valid, byte_cnt = 1, frame_done and det_clr pulses.
REQ-045 sof_rcv, symbols 0,1, then an empty symbol -> frame_err pulse, no data_valid, IDLE 1 cycle later.
REQ-046 sof_rcv, then a symbol with hits in slots 0 and 2 -> frame_err; byte_cnt = 0.
REQ-047 MAX_BYTES = 2, 3 bytes sent -> two data_valid pulses, then frame_err at the end of the 3rd byte.
REQ-048 en = 0 with sof_rcv -> stays IDLE and busy = 0; en dropped mid-byte -> frame_err on the next cycle.
REQ-049 rst pulse mid-byte -> all outputs 0 in IDLE, no frame_err; a new sof_rcv then decodes normally.
